// File: rtl/pattern_fifo_checker.sv
// Pattern FIFO checker: reads PATTERN_FIFO words, compares them against a regenerated pattern and
// keeps mismatch statistics. Define PATTERN_CHECK_STOP_ON_ERR_EN to end a run at the first mismatch.
module pattern_fifo_checker #(
  parameter int unsigned CHECK_WORDS = 32'h0001_0000,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 digiclk,
  input  logic                 resetn,
  input  logic [1:0]           pattern,
  input  logic                 check_start,
  input  logic                 check_clear,
  input  logic                 fifo_empty,
  input  logic [31:0]          fifo_rdata,
  output logic                 fifo_re,
  output logic                 chk_busy,
  output logic                 chk_done,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          word_cnt,
  output logic [31:0]          first_err_idx,
  output logic [31:0]          first_err_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam bit Unlimited = (CHECK_WORDS == 0);

  state_e      state_q, state_d;
  logic [1:0]  pat_q;
  logic [31:0] issued_q, issued_d;
  logic        rvalid_q;
  logic        start_run;
  logic        cmp_en;
  logic        mismatch;

  function automatic logic [31:0] exp_word(input logic [1:0] p, input logic [31:0] w);
    logic [31:0] v;
    unique case (p)
      2'd0:    v = w;
      2'd1:    v = ~w;
      2'd2:    v = w[1] ? 32'hFFFF_FFFF : 32'h0000_0000;
      default: v = w[1] ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
    return v;
  endfunction

  // Reads that land after the run has left RUN/DRAIN (abort or early stop) are dropped.
  assign cmp_en   = rvalid_q && ((state_q == StRun) || (state_q == StDrain));
  assign mismatch = cmp_en && (fifo_rdata != exp_word(pat_q, word_cnt));

  assign chk_busy = (state_q == StRun) || (state_q == StDrain);
  assign chk_done = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    fifo_re   = 1'b0;
    start_run = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (check_start) begin
          state_d   = StRun;
          start_run = 1'b1;
          issued_d  = '0;
        end
      end
      StRun: begin
        fifo_re = !fifo_empty && (Unlimited || (issued_q < CHECK_WORDS));
        if (fifo_re) begin
          issued_d = issued_q + 32'd1;
        end
        if (!Unlimited && (issued_d == CHECK_WORDS)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rvalid_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
    if (mismatch) begin
      state_d = StDone;
    end
`endif
    // Clear also suppresses the read so no word is popped and then thrown away.
    if (check_clear) begin
      state_d   = StIdle;
      issued_d  = '0;
      fifo_re   = 1'b0;
      start_run = 1'b0;
    end
  end

  always_ff @(posedge digiclk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      pat_q          <= 2'd0;
      issued_q       <= '0;
      rvalid_q       <= 1'b0;
      chk_err        <= 1'b0;
      err_cnt        <= '0;
      word_cnt       <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      rvalid_q <= fifo_re;
      if (check_clear || start_run) begin
        if (start_run) begin
          pat_q <= pattern;
        end
        chk_err        <= 1'b0;
        err_cnt        <= '0;
        word_cnt       <= '0;
        first_err_idx  <= '0;
        first_err_data <= '0;
      end else if (cmp_en) begin
        word_cnt <= word_cnt + 32'd1;
        if (mismatch) begin
          chk_err <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (!chk_err) begin
            first_err_idx  <= word_cnt;
            first_err_data <= fifo_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_fifo_checker.sv
// Scoreboard bench for pattern_fifo_checker: a 16-word instance and an unlimited-run instance,
// each fed by a queue-based FIFO model, checked against a pattern reference model.
`timescale 1ns/1ps
module tb_pattern_fifo_checker;

  localparam int unsigned NA   = 16;
  localparam int unsigned NBIG = 70000;
`ifdef PATTERN_CHECK_STOP_ON_ERR_EN
  localparam bit Stop = 1'b1;
`else
  localparam bit Stop = 1'b0;
`endif

  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] wc;
    logic [15:0] ec;
    bit          err;
    logic [31:0] fi;
    logic [31:0] fd;
    bit          busy;
    bit          done;
  } exp_t;

  logic digiclk = 1'b0;
  logic resetn  = 1'b0;
  always #5 digiclk = ~digiclk;

  logic [1:0]  pattern_a = 2'd0, pattern_b = 2'd0;
  logic        start_a = 1'b0, clear_a = 1'b0, start_b = 1'b0, clear_b = 1'b0;
  logic        fifo_empty_a = 1'b1, fifo_empty_b = 1'b1;
  logic [31:0] fifo_rdata_a = '0, fifo_rdata_b = '0;
  logic        fifo_re_a, chk_busy_a, chk_done_a, chk_err_a;
  logic        fifo_re_b, chk_busy_b, chk_done_b, chk_err_b;
  logic [15:0] err_cnt_a, err_cnt_b;
  logic [31:0] word_cnt_a, first_err_idx_a, first_err_data_a;
  logic [31:0] word_cnt_b, first_err_idx_b, first_err_data_b;

  pattern_fifo_checker #(.CHECK_WORDS(NA), .ERR_CNT_W(16)) dut_a (
    .digiclk        (digiclk),
    .resetn         (resetn),
    .pattern        (pattern_a),
    .check_start    (start_a),
    .check_clear    (clear_a),
    .fifo_empty     (fifo_empty_a),
    .fifo_rdata     (fifo_rdata_a),
    .fifo_re        (fifo_re_a),
    .chk_busy       (chk_busy_a),
    .chk_done       (chk_done_a),
    .chk_err        (chk_err_a),
    .err_cnt        (err_cnt_a),
    .word_cnt       (word_cnt_a),
    .first_err_idx  (first_err_idx_a),
    .first_err_data (first_err_data_a)
  );

  pattern_fifo_checker #(.CHECK_WORDS(0), .ERR_CNT_W(16)) dut_b (
    .digiclk        (digiclk),
    .resetn         (resetn),
    .pattern        (pattern_b),
    .check_start    (start_b),
    .check_clear    (clear_b),
    .fifo_empty     (fifo_empty_b),
    .fifo_rdata     (fifo_rdata_b),
    .fifo_re        (fifo_re_b),
    .chk_busy       (chk_busy_b),
    .chk_done       (chk_done_b),
    .chk_err        (chk_err_b),
    .err_cnt        (err_cnt_b),
    .word_cnt       (word_cnt_b),
    .first_err_idx  (first_err_idx_b),
    .first_err_data (first_err_data_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // FIFO models: a read pops the head, data appears on the next cycle.
  logic [31:0] fq_a[$];
  logic [31:0] fq_b[$];
  logic [31:0] stage[$];
  bit          stall_en_a = 1'b0;
  int          viol = 0;
  int          re_done_a = 0;

  always @(posedge digiclk) begin
    if (fifo_re_a) begin
      if (fifo_empty_a || fq_a.size() == 0) viol <= viol + 1;
      if (fq_a.size() > 0) fifo_rdata_a <= fq_a.pop_front();
      if (chk_done_a) re_done_a <= re_done_a + 1;
    end
    if (fifo_re_b) begin
      if (fifo_empty_b || fq_b.size() == 0) viol <= viol + 1;
      if (fq_b.size() > 0) fifo_rdata_b <= fq_b.pop_front();
    end
  end

  always @(negedge digiclk) begin
    fifo_empty_a <= (fq_a.size() == 0) || (stall_en_a && ($urandom_range(0, 2) == 0));
    fifo_empty_b <= (fq_b.size() == 0);
  end

  // Scoreboard: done_q holds per-run results of dut_a; snap_q holds on-demand snapshots.
  exp_t done_q[$];
  exp_t snap_q[$];
  bit   done_prev_a = 1'b0;
  int   done_seen_a = 0;

  task automatic compare_out(input exp_t e);
    if (!e.sel) begin
      check({e.tag, ".word_cnt"}, word_cnt_a, e.wc);
      check({e.tag, ".err_cnt"}, {16'b0, err_cnt_a}, {16'b0, e.ec});
      check({e.tag, ".chk_err"}, {31'b0, chk_err_a}, {31'b0, e.err});
      check({e.tag, ".first_err_idx"}, first_err_idx_a, e.fi);
      check({e.tag, ".first_err_data"}, first_err_data_a, e.fd);
      check({e.tag, ".chk_busy"}, {31'b0, chk_busy_a}, {31'b0, e.busy});
      check({e.tag, ".chk_done"}, {31'b0, chk_done_a}, {31'b0, e.done});
    end else begin
      check({e.tag, ".word_cnt"}, word_cnt_b, e.wc);
      check({e.tag, ".err_cnt"}, {16'b0, err_cnt_b}, {16'b0, e.ec});
      check({e.tag, ".chk_err"}, {31'b0, chk_err_b}, {31'b0, e.err});
      check({e.tag, ".first_err_idx"}, first_err_idx_b, e.fi);
      check({e.tag, ".first_err_data"}, first_err_data_b, e.fd);
      check({e.tag, ".chk_busy"}, {31'b0, chk_busy_b}, {31'b0, e.busy});
      check({e.tag, ".chk_done"}, {31'b0, chk_done_b}, {31'b0, e.done});
    end
  endtask

  always @(negedge digiclk) begin
    exp_t e;
    if (chk_done_a && !done_prev_a) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got chk_done=1, expected no completed run");
      end else begin
        e = done_q.pop_front();
        compare_out(e);
      end
      done_seen_a <= done_seen_a + 1;
    end
    done_prev_a <= chk_done_a;
    while (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      compare_out(e);
    end
  end

  // Reference: generator stream value of word w.
  function automatic logic [31:0] gen_word(input logic [1:0] p, input int unsigned w);
    logic [31:0] wv;
    wv = 32'(w);
    case (p)
      2'd0:    return wv;
      2'd1:    return 32'hFFFF_FFFF - wv;
      2'd2:    return ((w / 2) % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
      default: return ((w / 2) % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  task automatic make_zero(input string tag, input bit sel, output exp_t e);
    e.tag = tag; e.sel = sel; e.wc = '0; e.ec = '0; e.err = 1'b0;
    e.fi = '0; e.fd = '0; e.busy = 1'b0; e.done = 1'b0;
  endtask

  // Expected result of checking the first n words of stage against pattern p.
  task automatic model_run(input string tag, input bit sel, input logic [1:0] p,
                           input int unsigned n, input bit unlimited, output exp_t e);
    make_zero(tag, sel, e);
    for (int unsigned w = 0; w < n; w++) begin
      e.wc = 32'(w + 1);
      if (stage[w] != gen_word(p, w)) begin
        if (!e.err) begin
          e.fi = 32'(w);
          e.fd = stage[w];
        end
        e.err = 1'b1;
        if (e.ec != 16'hFFFF) e.ec = e.ec + 16'd1;
        if (Stop) break;
      end
    end
    e.done = unlimited ? (Stop && e.err) : 1'b1;
    e.busy = !e.done;
  endtask

  task automatic fill_stage(input logic [1:0] p, input int unsigned n);
    stage.delete();
    for (int unsigned w = 0; w < n; w++) stage.push_back(gen_word(p, w));
  endtask

  task automatic run_a(input string tag, input logic [1:0] p, input bit stall, input bit noise);
    exp_t e;
    int   seen;
    bit   got;
    model_run(tag, 1'b0, p, NA, 1'b0, e);
    done_q.push_back(e);
    seen = done_seen_a;
    @(negedge digiclk);
    fq_a = stage;
    stall_en_a = stall;
    @(negedge digiclk);
    pattern_a = p;
    start_a   = 1'b1;
    @(negedge digiclk);
    start_a   = 1'b0;
    pattern_a = p ^ 2'b11;
    if (noise) begin
      // Start pulse and a changed pattern while busy must both be ignored.
      @(negedge digiclk);
      start_a = 1'b1;
      @(negedge digiclk);
      start_a = 1'b0;
    end
    for (int i = 0; i < 400 && done_seen_a == seen; i++) @(negedge digiclk);
    got = (done_seen_a != seen);
    check({tag, ".done_seen"}, {31'b0, got}, 32'd1);
    if (!got && done_q.size() > 0) void'(done_q.pop_back());
    stall_en_a = 1'b0;
    @(negedge digiclk);
    fq_a.delete();
    @(negedge digiclk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [1:0]  p;
    logic [31:0] d;

    repeat (3) @(negedge digiclk);
    resetn = 1'b1;
    @(negedge digiclk);
    make_zero("reset_a", 1'b0, e); snap_q.push_back(e);
    make_zero("reset_b", 1'b1, e); snap_q.push_back(e);
    @(negedge digiclk);

    fill_stage(2'd0, NA);
    run_a("incr16", 2'd0, 1'b0, 1'b1);

    fill_stage(2'd3, NA);
    stage[5] = 32'h0000_0000;
    stage[9] = 32'h1234_5678;
    run_a("pat3_err5", 2'd3, 1'b0, 1'b0);

    fill_stage(2'd0, NA);
    run_a("incr_stall", 2'd0, 1'b1, 1'b1);

    fill_stage(2'd1, NA);
    stage[3] = 32'hDEAD_BEEF;
    run_a("decr_err3", 2'd1, 1'b0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      p = 2'($urandom_range(0, 3));
      stage.delete();
      for (int unsigned w = 0; w < NA; w++) begin
        d = gen_word(p, w);
        if ($urandom_range(0, 7) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
        stage.push_back(d);
      end
      run_a($sformatf("rand%0d", r), p, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Abort mid-run with start and clear together; clear must win.
    fill_stage(2'd0, NA);
    @(negedge digiclk);
    fq_a = stage;
    @(negedge digiclk);
    pattern_a = 2'd0;
    start_a   = 1'b1;
    @(negedge digiclk);
    start_a = 1'b0;
    repeat (5) @(negedge digiclk);
    clear_a = 1'b1;
    start_a = 1'b1;
    @(negedge digiclk);
    clear_a = 1'b0;
    start_a = 1'b0;
    make_zero("clear_a", 1'b0, e); snap_q.push_back(e);
    fq_a.delete();
    repeat (4) @(negedge digiclk);
    make_zero("clear_a_idle", 1'b0, e); snap_q.push_back(e);
    @(negedge digiclk);

    fill_stage(2'd2, NA);
    run_a("after_clear", 2'd2, 1'b1, 1'b0);

    // Long DECR run across the 65536-word block boundary on the unlimited instance.
    stage.delete();
    for (int unsigned w = 0; w < NBIG; w++) begin
      stage.push_back(32'hFFFF_FFFF - 32'((w / 65536) * 65536 + (w % 65536)));
    end
    stage[NBIG-1] = stage[NBIG-1] ^ 32'h0000_0100;
    model_run("decr70k", 1'b1, 2'd1, NBIG, 1'b1, e);
    @(negedge digiclk);
    fq_b = stage;
    @(negedge digiclk);
    pattern_b = 2'd1;
    start_b   = 1'b1;
    @(negedge digiclk);
    start_b   = 1'b0;
    pattern_b = 2'd0;
    for (int i = 0; i < NBIG + 1000 && fq_b.size() > 0; i++) @(negedge digiclk);
    check("decr70k.drained", 32'(fq_b.size()), 32'd0);
    repeat (4) @(negedge digiclk);
    snap_q.push_back(e);
    @(negedge digiclk);
    clear_b = 1'b1;
    @(negedge digiclk);
    clear_b = 1'b0;
    make_zero("clear_b", 1'b1, e); snap_q.push_back(e);
    repeat (3) @(negedge digiclk);

    check("re_while_empty", 32'(viol), 32'd0);
    check("re_in_done", 32'(re_done_a), 32'd0);
    check("pending_runs", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
